// File: rtl/fft_reorder_ctrl.sv
// fft_reorder_ctrl: ping-pong bit-reversal reorder stage for the FFT pipeline.
// One frame of N = 2**AddrWidth samples is written in natural order into one
// single-port SRAM bank while the other, already full bank is read back in
// bit-reversed address order through a 2-entry output FIFO.
//
// Ports:
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o/in_data_i      natural-order input stream
//   out_valid_o/out_ready_i/out_data_o   bit-reversed output stream
//   out_last_o                    last sample of a frame
//   bankX_wen_o/addr_o/wdata_o    SRAM bank X control (X = 0, 1)
//   bankX_rdata_i                 SRAM bank X read data, 1-cycle latency
//   frame_cnt_o, overflow_o       status, only with FFT_REORDER_STATUS_EN
//
// Optional feature macro: FFT_REORDER_STATUS_EN
module fft_reorder_ctrl #(
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned DataWidth = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_last_o,
`ifdef FFT_REORDER_STATUS_EN
    output logic [15:0]          frame_cnt_o,
    output logic                 overflow_o,
`endif
    output logic                 bank0_wen_o,
    output logic [AddrWidth-1:0] bank0_addr_o,
    output logic [DataWidth-1:0] bank0_wdata_o,
    input  logic [DataWidth-1:0] bank0_rdata_i,
    output logic                 bank1_wen_o,
    output logic [AddrWidth-1:0] bank1_addr_o,
    output logic [DataWidth-1:0] bank1_wdata_o,
    input  logic [DataWidth-1:0] bank1_rdata_i
);

    localparam int unsigned N = 1 << AddrWidth;
    localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(N - 1);

    function automatic logic [AddrWidth-1:0] bitrev(input logic [AddrWidth-1:0] a);
        logic [AddrWidth-1:0] r;
        for (int unsigned i = 0; i < AddrWidth; i++) begin
            r[i] = a[AddrWidth-1-i];
        end
        return r;
    endfunction

    logic [AddrWidth-1:0]            wr_cnt, rd_cnt;
    logic                            wr_bank, rd_bank;
    logic [1:0]                      full, full_nxt;
    logic                            accept, issue, pop, credit;
    logic [1:0]                      occ_after_pop;
    logic [AddrWidth-1:0]            rd_addr;
    logic                            rd_pend, rd_pend_last, rd_pend_bank;
    logic [1:0][DataWidth-1:0]       fifo_data;
    logic [1:0]                      fifo_last;
    logic                            fifo_wptr, fifo_rptr;
    logic [1:0]                      fifo_cnt;
    logic [AddrWidth-1:0]            bank0_addr_q, bank1_addr_q;
    logic [DataWidth-1:0]            rdata_sel;

    // Handshakes; ready is held low while reset is asserted.
    assign in_ready_o  = rst_ni & ~full[wr_bank];
    assign accept      = in_valid_i & in_ready_o;
    assign out_valid_o = (fifo_cnt != 2'd0);
    assign pop         = out_valid_o & out_ready_i;

    // A read is issued only if its data is guaranteed a FIFO slot on arrival.
    assign occ_after_pop = fifo_cnt - 2'(pop);
    assign credit        = (occ_after_pop + 2'(rd_pend)) < 2'd2;
    assign issue         = full[rd_bank] & credit;
    assign rd_addr       = bitrev(rd_cnt);

    assign out_data_o = fifo_data[fifo_rptr];
    assign out_last_o = out_valid_o & fifo_last[fifo_rptr];
    assign rdata_sel  = rd_pend_bank ? bank1_rdata_i : bank0_rdata_i;

    assign bank0_wdata_o = in_data_i;
    assign bank1_wdata_o = in_data_i;

    // Bank port mux; the written bank is never full and the read bank always is.
    always_comb begin
        bank0_wen_o  = 1'b0;
        bank1_wen_o  = 1'b0;
        bank0_addr_o = bank0_addr_q;
        bank1_addr_o = bank1_addr_q;
        if (accept) begin
            if (wr_bank) begin
                bank1_wen_o  = 1'b1;
                bank1_addr_o = wr_cnt;
            end else begin
                bank0_wen_o  = 1'b1;
                bank0_addr_o = wr_cnt;
            end
        end
        if (issue) begin
            if (rd_bank) bank1_addr_o = rd_addr;
            else         bank0_addr_o = rd_addr;
        end
    end

    // Frame completion on either side updates its own full flag.
    always_comb begin
        full_nxt = full;
        if (accept && (wr_cnt == LastIdx)) full_nxt[wr_bank] = 1'b1;
        if (issue && (rd_cnt == LastIdx))  full_nxt[rd_bank] = 1'b0;
    end

    // Write/read counters, bank pointers and full flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            full         <= 2'b00;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            rd_pend_bank <= 1'b0;
            bank0_addr_q <= '0;
            bank1_addr_q <= '0;
        end else begin
            full         <= full_nxt;
            rd_pend      <= issue;
            rd_pend_last <= (rd_cnt == LastIdx);
            rd_pend_bank <= rd_bank;
            bank0_addr_q <= bank0_addr_o;
            bank1_addr_q <= bank1_addr_o;
            if (accept) begin
                wr_cnt <= wr_cnt + AddrWidth'(1);
                if (wr_cnt == LastIdx) wr_bank <= ~wr_bank;
            end
            if (issue) begin
                rd_cnt <= rd_cnt + AddrWidth'(1);
                if (rd_cnt == LastIdx) rd_bank <= ~rd_bank;
            end
        end
    end

    // 2-entry output FIFO fed by the read issued on the previous cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_data <= '0;
            fifo_last <= 2'b00;
            fifo_wptr <= 1'b0;
            fifo_rptr <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            if (rd_pend) begin
                fifo_data[fifo_wptr] <= rdata_sel;
                fifo_last[fifo_wptr] <= rd_pend_last;
                fifo_wptr            <= ~fifo_wptr;
            end
            if (pop) fifo_rptr <= ~fifo_rptr;
            fifo_cnt <= fifo_cnt + 2'(rd_pend) - 2'(pop);
        end
    end

`ifdef FFT_REORDER_STATUS_EN
    // Frames delivered downstream, and a sticky flag for input pushed at a full stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_o <= 16'd0;
            overflow_o  <= 1'b0;
        end else begin
            if (pop && out_last_o) frame_cnt_o <= frame_cnt_o + 16'd1;
            if (in_valid_i && full[0] && full[1]) overflow_o <= 1'b1;
        end
    end
`endif

endmodule
